// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops FIFO words and packs PACK of them into one valid/ready beat.
// Define FIFO_RD_PACKER_FLUSH_EN to add the flush input and out_lanes output.

module fifo_rd_packer #(
    parameter int FIFO_WIDTH = 16,
    parameter int PACK       = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk_b,
    input  logic                       rst,
    input  logic [FIFO_WIDTH-1:0]      fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_ren,
    output logic [FIFO_WIDTH*PACK-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef FIFO_RD_PACKER_FLUSH_EN
    input  logic                       flush,
    output logic [$clog2(PACK):0]      out_lanes,
`endif
    output logic [CNT_WIDTH-1:0]       beat_cnt
);

    localparam int LW = $clog2(PACK) + 1;
    localparam int IW = $clog2(PACK);
    localparam logic [LW-1:0] PACK_L = LW'(PACK);

    typedef enum logic {S_FILL, S_HOLD} state_t;
    typedef logic [PACK-1:0][FIFO_WIDTH-1:0] lanes_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          lane_cnt_q, lane_cnt_d;
    logic                   inflight_q;
    lanes_t                 asm_q, asm_d;
    lanes_t                 data_q, data_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [LW-1:0]          occ;
    logic                   stop;
    logic                   go_hold;
    logic                   accept;
    logic                   transfer;

`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic                   pend_q, pend_d;
    logic [LW-1:0]          lanes_q, lanes_d;
    logic                   flush_acc;
`endif

    // Read issue is gated by rst so no pop happens while the block is held in reset.
    always_comb begin
        occ = lane_cnt_q + LW'(inflight_q);
`ifdef FIFO_RD_PACKER_FLUSH_EN
        flush_acc = flush && (state_q == S_FILL)
                    && ((lane_cnt_q != '0) || inflight_q);
        stop      = pend_q || flush_acc;
`else
        stop      = 1'b0;
`endif
        fifo_ren = rst && !fifo_empty && (occ < PACK_L)
                   && (state_q == S_FILL) && !stop;
    end

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        asm_d      = asm_q;
        data_d     = data_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        accept     = valid_q && out_ready;
        transfer   = (state_q == S_HOLD) && (!valid_q || out_ready);
        if (inflight_q) begin
            asm_d[lane_cnt_q[IW-1:0]] = fifo_dout;
            lane_cnt_d = lane_cnt_q + LW'(1);
        end
        go_hold = (lane_cnt_d == PACK_L);
`ifdef FIFO_RD_PACKER_FLUSH_EN
        lanes_d = lanes_q;
        pend_d  = pend_q || flush_acc;
        go_hold = go_hold || (stop && !inflight_q && (lane_cnt_q != '0));
`endif
        if (accept) begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            valid_d = 1'b0;
        end
        // Clearing the assembler leaves unused lanes of a flushed beat at zero.
        if (transfer) begin
            data_d     = asm_q;
            valid_d    = 1'b1;
            lane_cnt_d = '0;
            asm_d      = '0;
            state_d    = S_FILL;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            lanes_d    = lane_cnt_q;
`endif
        end else if ((state_q == S_FILL) && go_hold) begin
            state_d = S_HOLD;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            pend_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_b or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FILL;
            lane_cnt_q <= '0;
            inflight_q <= 1'b0;
            asm_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            pend_q     <= 1'b0;
            lanes_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            inflight_q <= fifo_ren;
            asm_q      <= asm_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            pend_q     <= pend_d;
            lanes_q    <= lanes_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign beat_cnt  = cnt_q;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    assign out_lanes = lanes_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed bench for fifo_rd_packer (PACK=2, 16-bit words)
// with a 1-cycle-latency FIFO model and an accepted-beat scoreboard.

module tb_fifo_rd_packer;

    logic        clk_b = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] beat_cnt;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic        flush = 1'b0;
    logic [1:0]  out_lanes;
`endif

    fifo_rd_packer #(
        .FIFO_WIDTH(16),
        .PACK(2),
        .CNT_WIDTH(16)
    ) dut (
        .clk_b(clk_b),
        .rst(rst),
        .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_ren(fifo_ren),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef FIFO_RD_PACKER_FLUSH_EN
        .flush(flush),
        .out_lanes(out_lanes),
`endif
        .beat_cnt(beat_cnt)
    );

    always #5 clk_b = ~clk_b;

    logic [15:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        gate_empty = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr) || gate_empty;

    always @(posedge clk_b) begin
        if (fifo_ren) begin
            fifo_dout <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int          pops = 0;
    int          viol = 0;
    logic [31:0] beats [$];

    always @(posedge clk_b) begin
        if (fifo_ren) pops <= pops + 1;
        if (fifo_ren && fifo_empty) viol <= viol + 1;
        if (out_valid && out_ready) beats.push_back(out_data);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_b);
        #1;
    endtask

    initial begin
        int p0;
        #2 rst = 1'b0;

        // reset with two words waiting, then first-beat latency
        push(16'h1111);
        push(16'h2222);
        cyc(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ren", fifo_ren, 0);
        chk("rst_cnt", beat_cnt, 0);
        rst = 1'b1;
        #1;
        chk("t1_ren_c0", fifo_ren, 1);
        cyc(1);
        chk("t1_ren_c1", fifo_ren, 1);
        cyc(1);
        chk("t1_ren_c2", fifo_ren, 0);
        cyc(1);
        chk("t1_valid_c3", out_valid, 0);
        cyc(1);
        chk("t1_valid_c4", out_valid, 1);
        chk("t1_data_c4", out_data, 32'h2222_1111);
`ifdef FIFO_RD_PACKER_FLUSH_EN
        chk("t1_lanes", out_lanes, 2);
`endif
        out_ready = 1'b1;
        cyc(1);
        chk("t1_cnt", beat_cnt, 1);
        chk("t1_valid_c5", out_valid, 0);

        // eight-word stream with downstream always ready
        beats.delete();
        p0 = pops;
        for (int i = 1; i <= 8; i++) push(16'(i));
        for (int i = 0; i < 40 && beats.size() < 4; i++) cyc(1);
        chk("t2_nbeats", beats.size(), 4);
        chk("t2_b0", beats[0], 32'h0002_0001);
        chk("t2_b1", beats[1], 32'h0004_0003);
        chk("t2_b2", beats[2], 32'h0006_0005);
        chk("t2_b3", beats[3], 32'h0008_0007);
        chk("t2_pops", pops - p0, 8);
        chk("t2_cnt", beat_cnt, 5);

        // backpressure: six words queued, out_ready low for ten cycles
        out_ready = 1'b0;
        beats.delete();
        p0 = pops;
        for (int i = 0; i < 6; i++) push(16'h0011 + 16'(i));
        cyc(6);
        chk("t3_valid_c6", out_valid, 1);
        chk("t3_data_c6", out_data, 32'h0012_0011);
        cyc(4);
        chk("t3_data_c10", out_data, 32'h0012_0011);
        chk("t3_ren_c10", fifo_ren, 0);
        chk("t3_pops_c10", pops - p0, 4);
        out_ready = 1'b1;
        cyc(1);
        chk("t3_valid_c11", out_valid, 1);
        chk("t3_data_c11", out_data, 32'h0014_0013);
        for (int i = 0; i < 30 && beats.size() < 3; i++) cyc(1);
        chk("t3_nbeats", beats.size(), 3);
        chk("t3_b0", beats[0], 32'h0012_0011);
        chk("t3_b1", beats[1], 32'h0014_0013);
        chk("t3_b2", beats[2], 32'h0016_0015);
        chk("t3_cnt", beat_cnt, 8);

        // fifo_empty toggling every cycle
        beats.delete();
        for (int i = 0; i < 6; i++) push(16'hA000 + 16'(i));
        for (int i = 0; i < 60 && beats.size() < 3; i++) begin
            gate_empty = ~gate_empty;
            cyc(1);
        end
        gate_empty = 1'b0;
        chk("t4_viol", viol, 0);
        chk("t4_nbeats", beats.size(), 3);
        chk("t4_b0", beats[0], 32'hA001_A000);
        chk("t4_b1", beats[1], 32'hA003_A002);
        chk("t4_b2", beats[2], 32'hA005_A004);
        chk("t4_cnt", beat_cnt, 11);

        // reset with one lane filled and one read in flight
        cyc(2);
        beats.delete();
        push(16'hB001);
        push(16'hB002);
        push(16'hB003);
        cyc(2);
        rst = 1'b0;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_cnt", beat_cnt, 0);
        chk("t5_ren", fifo_ren, 0);
        cyc(2);
        rst = 1'b1;
        push(16'hC001);
        for (int i = 0; i < 20 && beats.size() < 1; i++) cyc(1);
        chk("t5_nbeats", beats.size(), 1);
        chk("t5_b0", beats[0], 32'hC001_B003);
        chk("t5_cnt_after", beat_cnt, 1);

`ifdef FIFO_RD_PACKER_FLUSH_EN
        // flush of a single-lane partial beat
        cyc(2);
        push(16'h000A);
        cyc(4);
        chk("t6_idle", out_valid, 0);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) cyc(1);
        chk("t6_valid", out_valid, 1);
        chk("t6_data", out_data, 32'h0000_000A);
        chk("t6_lanes", out_lanes, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer on the clk_b domain of the dual-clock FIFO.
- Pops FIFO_WIDTH-bit words via the FIFO's ren/dout/empty interface, which has 1-cycle read latency.
- Packs PACK consecutive words into one wide word and presents it on a valid/ready stream to downstream logic.
- Absorbs the FIFO read latency and downstream backpressure without losing or duplicating words.

Parameters:
- FIFO_WIDTH, 16: width of one FIFO word; must match the FIFO instance.
- PACK, 2: words per output beat; power of two, 2..8.
- CNT_WIDTH, 16: width of the delivered-beat counter.

Ports:
- clk_b  in  1  read-domain clock (same clock as the FIFO read port).
- rst  in  1  asynchronous, active-low reset.
- fifo_dout  in  FIFO_WIDTH  FIFO read data; valid the cycle after fifo_ren=1.
- fifo_empty  in  1  FIFO empty flag.
- fifo_ren  out  1  FIFO read enable.
- out_data  out  FIFO_WIDTH*PACK  packed word; first-popped word in bits [FIFO_WIDTH-1:0].
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  downstream accepts a beat when out_valid=1.
- beat_cnt  out  CNT_WIDTH  count of beats accepted downstream; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst=0, asynchronous): out_data=0, out_valid=0, fifo_ren=0, beat_cnt=0, lane_cnt=0, inflight=0, assembler cleared, state=S_FILL.
- Reset mid-operation: a read already in flight is discarded and partially assembled words are dropped.

Internal state:
- lane_cnt: 0..PACK.
- inflight: 1 bit; registered copy of fifo_ren.
- Assembler register: PACK lanes.
- Output register: out_data plus out_valid.
- occ = lane_cnt + inflight.

Read issue:
- fifo_ren = !fifo_empty && (occ < PACK) && state==S_FILL.
- fifo_ren is combinational from registered state and fifo_empty.
- fifo_ren is never asserted while fifo_empty=1.

Capture:
- When inflight=1, fifo_dout is written into lane[lane_cnt], and lane_cnt increments.

State machine:
- S_FILL -> S_HOLD when lane_cnt reaches PACK.
- S_HOLD -> S_FILL when the assembler transfers to the output register.
  - Transfer condition: out_valid==0, or out_valid && out_ready.
  - On transfer: out_data <= assembler, out_valid <= 1, lane_cnt <= 0.
- S_HOLD issues no reads.

Output handshake:
- A beat is accepted when out_valid && out_ready.
- beat_cnt increments by 1 on each accepted beat.
- On acceptance with no simultaneous transfer, out_valid <= 0.
- out_data is stable while out_valid=1 and out_ready=0.
- Simultaneous accept and transfer in one cycle loads the new beat; out_valid stays 1.
- out_ready is ignored when out_valid=0.

Latency and throughput:
- Latency: the last word's fifo_ren cycle + 3 cycles to out_valid=1 (capture, transfer, register).
- Sustained throughput: PACK words per PACK+1 cycles with the FIFO non-empty and out_ready=1.

Boundaries:
- fifo_empty rising mid-beat stalls assembly; partial lanes are held indefinitely.
- Wrap of beat_cnt from 2^CNT_WIDTH-1 to 0 is silent.
- Words are never reordered or dropped, except on reset.

Optional Feature:
- Macro: FIFO_RD_PACKER_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit) and output out_lanes (log2(PACK)+1 bits).
  - flush=1 in S_FILL with lane_cnt>0 stops issuing reads, waits for inflight=0, then transfers the partial assembler as a beat.
  - Unused lanes in a flushed beat are 0.
  - out_lanes is PACK for full beats and lane_cnt for flushed beats.
  - flush with lane_cnt=0 and inflight=0 is ignored.
  - out_lanes resets to 0.
- Undefined: no flush port, no out_lanes; partial data waits for more words.

Test Plan:
- Reset while FIFO holds 0x1111, 0x2222 -> after release: fifo_ren=1 on the first cycle, out_data=0x22221111, out_valid=1 at read cycle+4, beat_cnt=1 after acceptance.
- 8 words 0x0001..0x0008, out_ready=1, PACK=2 -> beats 0x00020001, 0x00040003, 0x00060005, 0x00080007 in order; 8 pops in 12 cycles; beat_cnt=4.
- out_ready=0 for 10 cycles with 6 words queued -> out_data held constant; fifo_ren low once the assembler is full; exactly 2 beats buffered; no word lost after out_ready=1.
- fifo_empty toggles every cycle during a stream of 0xA000..0xA005 -> fifo_ren never high while fifo_empty=1; output order preserved.
- rst asserted with inflight=1 and lane_cnt=1 -> all outputs 0 immediately (asynchronous); next beat after release contains only post-reset words.
- With FIFO_RD_PACKER_FLUSH_EN, PACK=4: 3 words 0x0A, 0x0B, 0x0C then flush -> out_data=0x0000_000C_000B_000A, out_lanes=3.
